// File: rtl/cam_byte_capture.sv
// DVP camera front end: resynchronises the sensor bus, waits out sensor settling,
// gates whole frames on transfer_flag and checks each captured frame's geometry.
module cam_byte_capture #(
    parameter logic [15:0] CMOS_H_PIXEL = 16'd640,
    parameter logic [15:0] CMOS_V_PIXEL = 16'd480,
    parameter logic [3:0]  WAIT_FRAME   = 4'd10
) (
    input  logic        cam_pclk,
    input  logic        rst_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        cfg_done,
    input  logic        transfer_flag,
    output logic        img_vsync,
    output logic        img_data_en,
    output logic [7:0]  img_data,
    output logic        frame_active,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    localparam logic [16:0] LineBytes = {CMOS_H_PIXEL, 1'b0};

    typedef enum logic [1:0] {StWaitCfg, StSettle, StIdle, StCapture} state_e;

    state_e      state_q, state_d;
    logic        vsync_d0_q, vsync_d1_q, href_d0_q, href_d1_q;
    logic [7:0]  data_d0_q, data_d1_q;
    logic [3:0]  settle_cnt_q, settle_cnt_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic        err_acc_q, err_acc_d;
    logic        img_data_en_q, img_data_en_d;
    logic [7:0]  img_data_q, img_data_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic        vs_fall, vs_rise, hr_fall, byte_vld, line_bad, err_nx;
    logic [15:0] byte_cnt_inc, line_cnt_inc;

    assign vs_fall  = vsync_d1_q & ~vsync_d0_q;
    assign vs_rise  = ~vsync_d1_q & vsync_d0_q;
    assign hr_fall  = href_d1_q & ~href_d0_q;
    assign byte_vld = href_d1_q & ~vsync_d1_q;

    // The last byte of a line is still in d1 on the hr_fall cycle, so include it here.
    assign byte_cnt_inc = (byte_vld && byte_cnt_q != 16'hFFFF) ? byte_cnt_q + 16'd1 : byte_cnt_q;
    assign line_cnt_inc = (hr_fall && line_cnt_q != 16'hFFFF) ? line_cnt_q + 16'd1 : line_cnt_q;
    assign line_bad     = hr_fall && ({1'b0, byte_cnt_inc} != LineBytes);
    assign err_nx       = err_acc_q | line_bad;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        line_cnt_d   = line_cnt_q;
        err_acc_d    = err_acc_q;
        frame_done_d = 1'b0;
        frame_err_d  = frame_err_q;
        frame_cnt_d  = frame_cnt_q;

        if (!cfg_done) begin
            state_d = StWaitCfg;
        end else begin
            unique case (state_q)
                StWaitCfg: begin
                    state_d      = StSettle;
                    settle_cnt_d = 4'd0;
                end
                StSettle: begin
                    if (vs_rise) begin
                        settle_cnt_d = settle_cnt_q + 4'd1;
                        if (settle_cnt_q == WAIT_FRAME - 4'd1) state_d = StIdle;
                    end
                end
                StIdle: begin
                    if (vs_fall && transfer_flag) begin
                        state_d    = StCapture;
                        byte_cnt_d = 16'd0;
                        line_cnt_d = 16'd0;
                        err_acc_d  = 1'b0;
                    end
                end
                StCapture: begin
                    byte_cnt_d = hr_fall ? 16'd0 : byte_cnt_inc;
                    line_cnt_d = line_cnt_inc;
                    err_acc_d  = err_nx;
                    if (vs_rise) begin
                        state_d      = StIdle;
                        frame_done_d = 1'b1;
                        frame_err_d  = err_nx | (line_cnt_inc != CMOS_V_PIXEL);
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                    end
                end
                default: state_d = StWaitCfg;
            endcase
        end
    end

    // Gate on next state so an abort drops the byte stream in the same cycle as img_vsync.
    always_comb begin
        img_data_en_d = 1'b0;
        img_data_d    = 8'd0;
        if (state_d == StCapture && byte_vld) begin
            img_data_en_d = 1'b1;
            img_data_d    = data_d1_q;
        end
    end

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d0_q    <= 1'b0;
            vsync_d1_q    <= 1'b0;
            href_d0_q     <= 1'b0;
            href_d1_q     <= 1'b0;
            data_d0_q     <= 8'd0;
            data_d1_q     <= 8'd0;
            state_q       <= StWaitCfg;
            settle_cnt_q  <= 4'd0;
            byte_cnt_q    <= 16'd0;
            line_cnt_q    <= 16'd0;
            err_acc_q     <= 1'b0;
            img_data_en_q <= 1'b0;
            img_data_q    <= 8'd0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            vsync_d0_q    <= cam_vsync;
            vsync_d1_q    <= vsync_d0_q;
            href_d0_q     <= cam_href;
            href_d1_q     <= href_d0_q;
            data_d0_q     <= cam_data;
            data_d1_q     <= data_d0_q;
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            line_cnt_q    <= line_cnt_d;
            err_acc_q     <= err_acc_d;
            img_data_en_q <= img_data_en_d;
            img_data_q    <= img_data_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign img_vsync    = (state_q != StCapture);
    assign frame_active = (state_q == StCapture);
    assign img_data_en  = img_data_en_q;
    assign img_data     = img_data_q;
    assign frame_done   = frame_done_q;
    assign frame_err    = frame_err_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_cam_byte_capture.sv
// Scoreboard bench for cam_byte_capture on a 4x3-pixel sensor with a two-frame settle.
module tb_cam_byte_capture;

    localparam int H = 4;
    localparam int V = 3;

    logic        cam_pclk, rst_n, cam_vsync, cam_href, cfg_done, transfer_flag;
    logic [7:0]  cam_data;
    logic        img_vsync, img_data_en, frame_active, frame_done, frame_err;
    logic [7:0]  img_data;
    logic [15:0] frame_cnt;

    cam_byte_capture #(
        .CMOS_H_PIXEL(16'd4),
        .CMOS_V_PIXEL(16'd3),
        .WAIT_FRAME  (4'd2)
    ) dut (
        .cam_pclk     (cam_pclk),
        .rst_n        (rst_n),
        .cam_vsync    (cam_vsync),
        .cam_href     (cam_href),
        .cam_data     (cam_data),
        .cfg_done     (cfg_done),
        .transfer_flag(transfer_flag),
        .img_vsync    (img_vsync),
        .img_data_en  (img_data_en),
        .img_data     (img_data),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .frame_cnt    (frame_cnt)
    );

    initial cam_pclk = 1'b0;
    always #5 cam_pclk = ~cam_pclk;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q[$];
    bit          err_q[$];
    int          falls = 0;
    int          exp_falls = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [7:0]  ramp = 8'd0;
    logic [7:0]  dhist [3];
    logic        vs_prev = 1'b1;
    bit          mon_en = 1'b0;
    logic [7:0]  mon_e;
    bit          mon_err;

    // cam_data as seen at each edge, for the 3-cycle latency check
    always @(posedge cam_pclk) begin
        dhist[2] <= dhist[1];
        dhist[1] <= dhist[0];
        dhist[0] <= cam_data;
    end

    always @(negedge cam_pclk) begin
        if (mon_en) begin
            if (img_data_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %h, expected no byte", img_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (img_data !== mon_e) begin
                        errors++;
                        $display("FAIL byte_data: got %h, expected %h", img_data, mon_e);
                    end
                end
                checks++;
                if (img_data !== dhist[2]) begin
                    errors++;
                    $display("FAIL latency3: got %h, expected %h", img_data, dhist[2]);
                end
            end else begin
                checks++;
                if (img_data !== 8'd0) begin
                    errors++;
                    $display("FAIL idle_data_zero: got %h, expected 00", img_data);
                end
            end
            if (vs_prev && !img_vsync) falls++;
            vs_prev = img_vsync;
            if (frame_done) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame_done: got 1, expected 0");
                end else begin
                    mon_err = err_q.pop_front();
                    if (frame_err !== mon_err) begin
                        errors++;
                        $display("FAIL frame_err: got %b, expected %b", frame_err, mon_err);
                    end
                end
                checks++;
                if (frame_cnt !== exp_cnt) begin
                    errors++;
                    $display("FAIL frame_cnt_at_done: got %0d, expected %0d", frame_cnt, exp_cnt);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge cam_pclk);
            #1;
        end
    endtask

    // Drives one frame; 'cap' says whether the DUT should accept it.
    task automatic send_frame(input int nlines, input int bad_line, input int bad_len,
                              input bit cap, input bit flag_mid, input int abort_line);
        bit live;
        int len;
        live = cap;
        if (cap) exp_falls++;
        cam_vsync = 1'b0;
        tick(3);
        for (int l = 0; l < nlines; l++) begin
            len = (l == bad_line) ? bad_len : 2 * H;
            for (int b = 0; b < len; b++) begin
                cam_href = 1'b1;
                cam_data = ramp;
                if (live) exp_q.push_back(ramp);
                ramp++;
                tick(1);
            end
            cam_href = 1'b0;
            cam_data = 8'($urandom);
            tick(3);
            transfer_flag = flag_mid;
            if (l == abort_line) begin
                cfg_done = 1'b0;
                @(posedge cam_pclk);
                @(negedge cam_pclk);
                checks++;
                if (img_vsync !== 1'b1 || img_data_en !== 1'b0 || frame_active !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_outputs: got vs=%b en=%b act=%b, expected 1 0 0",
                             img_vsync, img_data_en, frame_active);
                end
                live = 1'b0;
            end
        end
        if (live) begin
            err_q.push_back((bad_line >= 0 && bad_line < nlines) || nlines != V);
            exp_cnt++;
        end
        cam_vsync = 1'b1;
        tick(6);
    endtask

    task automatic check_end(input string name);
        checks++;
        if (exp_q.size() != 0 || err_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got bytes=%0d frames=%0d left, expected 0 0",
                     name, exp_q.size(), err_q.size());
        end
        checks++;
        if (falls != exp_falls) begin
            errors++;
            $display("FAIL %s_vsync_falls: got %0d, expected %0d", name, falls, exp_falls);
        end
        checks++;
        if (frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL %s_frame_cnt: got %0d, expected %0d", name, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if (img_vsync !== 1'b1 || img_data_en !== 1'b0 || img_data !== 8'd0 ||
            frame_active !== 1'b0 || frame_done !== 1'b0 || frame_err !== 1'b0 ||
            frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: got vs=%b en=%b d=%h act=%b done=%b err=%b cnt=%0d, expected 1 0 00 0 0 0 0",
                     img_vsync, img_data_en, img_data, frame_active, frame_done, frame_err, frame_cnt);
        end
        rst_n = 1'b1;
        tick(5);
        mon_en = 1'b1;
    endtask

    task automatic test_settle_capture();
        cfg_done = 1'b1;
        tick(2);
        send_frame(V, -1, 0, 1'b0, 1'b1, -1);
        send_frame(V, -1, 0, 1'b0, 1'b1, -1);
        checks++;
        if (falls != 0) begin
            errors++;
            $display("FAIL settle_no_fall: got %0d falls, expected 0", falls);
        end
        send_frame(V, -1, 0, 1'b1, 1'b1, -1);
        send_frame(V, -1, 0, 1'b1, 1'b1, -1);
        checks++;
        if (frame_cnt !== 16'd2 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL settle_two_frames: got cnt=%0d err=%b, expected 2 0", frame_cnt, frame_err);
        end
        check_end("settle_capture");
    endtask

    task automatic test_transfer_gate();
        transfer_flag = 1'b0;
        tick(2);
        send_frame(V, -1, 0, 1'b0, 1'b1, -1);
        check_end("gated_frame");
        send_frame(V, -1, 0, 1'b1, 1'b1, -1);
        check_end("after_gate");
    endtask

    task automatic test_short_line();
        send_frame(V, 1, 2 * H - 1, 1'b1, 1'b1, -1);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL short_line_err: got %b, expected 1", frame_err);
        end
        send_frame(V, -1, 0, 1'b1, 1'b1, -1);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL good_after_short: got %b, expected 0", frame_err);
        end
        check_end("short_line");
    endtask

    task automatic test_short_frame();
        send_frame(V - 1, -1, 0, 1'b1, 1'b1, -1);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL short_frame_err: got %b, expected 1", frame_err);
        end
        check_end("short_frame");
    endtask

    task automatic test_cfg_drop();
        send_frame(V, -1, 0, 1'b1, 1'b1, 0);
        check_end("cfg_abort");
        cfg_done = 1'b1;
        tick(2);
        send_frame(V, -1, 0, 1'b0, 1'b1, -1);
        send_frame(V, -1, 0, 1'b0, 1'b1, -1);
        check_end("resettle");
        send_frame(V, -1, 0, 1'b1, 1'b1, -1);
        check_end("recapture");
    endtask

    initial begin
        rst_n         = 1'b0;
        cam_vsync     = 1'b1;
        cam_href      = 1'b0;
        cam_data      = 8'd0;
        cfg_done      = 1'b0;
        transfer_flag = 1'b1;
        test_reset();
        test_settle_capture();
        test_transfer_gate();
        test_short_line();
        test_short_frame();
        test_cfg_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cam_byte_capture.md
Name: cam_byte_capture

Overview:
- Camera-side front end of the OV5640 Ethernet image path, clocked by cam_pclk.
- Registers the raw DVP bus (vsync/href/8-bit data) and holds output off until sensor configuration has finished and WAIT_FRAME frames have settled.
- Gates whole frames on transfer_flag and delivers a clean byte stream (img_vsync / img_data_en / img_data) to the downstream packetiser.
- Checks every captured frame's geometry against the configured resolution and reports per-frame status.

Parameters:
CMOS_H_PIXEL, 16'd640, pixels per line; expected bytes per line = 2*CMOS_H_PIXEL (RGB565)
CMOS_V_PIXEL, 16'd480, lines per frame
WAIT_FRAME, 4'd10, vsync rising edges to discard after cfg_done before capture is allowed

Ports:
cam_pclk        input   1   pixel clock; all logic in this domain
rst_n           input   1   reset, asynchronous, active-low
cam_vsync       input   1   sensor frame sync; high = vertical blanking
cam_href        input   1   sensor line valid
cam_data        input   8   sensor byte
cfg_done        input   1   sensor register configuration complete (level)
transfer_flag   input   1   1 = capture enabled; sampled only at frame start
img_vsync       output  1   gated frame sync to packetiser; low only during an accepted frame
img_data_en     output  1   byte valid
img_data        output  8   byte; 0 when img_data_en=0
frame_active    output  1   high while in S_CAPTURE
frame_done      output  1   1-cycle pulse at end of each captured frame
frame_err       output  1   geometry status of last captured frame; updated with frame_done
frame_cnt       output  16  captured-frame count, wraps 0xFFFF->0

Behaviour:
- Input stage: cam_vsync/href/data registered twice (d0, d1).
  - vs_fall = d1 & ~d0 (frame start); vs_rise = ~d1 & d0 (frame end); hr_fall = d1 & ~d0 on href.
- Reset values: img_vsync=1; all other outputs 0; state S_WAIT_CFG; all counters 0.
- FSM:
  - S_WAIT_CFG: cfg_done=1 -> S_SETTLE with settle_cnt=0.
  - S_SETTLE: settle_cnt increments on each vs_rise; at settle_cnt==WAIT_FRAME-1 together with a vs_rise -> S_IDLE.
  - S_IDLE: on vs_fall with transfer_flag=1 -> S_CAPTURE; clear byte_cnt, line_cnt and err_acc. With transfer_flag=0 the frame is skipped and the state stays S_IDLE.
  - S_CAPTURE: on vs_rise -> S_IDLE. That cycle: frame_done=1; frame_err = err_acc | (line_cnt != CMOS_V_PIXEL); frame_cnt+1.
  - cfg_done=0 in any state -> S_WAIT_CFG next cycle. An aborted capture gives no frame_done and no frame_cnt change.
- img_vsync = 0 only while the registered state is S_CAPTURE, otherwise 1.
  - The packetiser therefore sees exactly one falling edge per accepted frame and none during settle or skipped frames.
- Data path, S_CAPTURE only: img_data_en = href_d1 & ~vsync_d1; img_data = data_d1.
  - Latency is cam_data -> img_data = 3 cam_pclk cycles (2 input registers + 1 output register).
  - Outside S_CAPTURE: img_data_en=0 and img_data=0.
- Geometry:
  - byte_cnt is 16-bit and increments per valid byte, saturating at 0xFFFF.
  - On hr_fall: if byte_cnt != 2*CMOS_H_PIXEL then err_acc=1; line_cnt+1 (16-bit, saturating); byte_cnt=0.
  - href already high at frame start: bytes are counted from the first cycle in S_CAPTURE, so a short line flags an error.
- transfer_flag change mid-frame: ignored; the current frame completes. A new value takes effect at the next vs_fall.
- Simultaneous hr_fall and vs_rise: the line is counted first and then enters the line_cnt check.
- frame_err holds its value until the next frame_done. frame_active = (state==S_CAPTURE).
- Async reset mid-frame: all outputs return to reset values immediately; the settle sequence restarts once cfg_done is seen.

Test Plan:
1. Reset, cfg_done=1, transfer_flag=1, WAIT_FRAME=2, 4 frames of 4x3 pixels (CMOS_H_PIXEL=4, CMOS_V_PIXEL=3) -> no img_vsync fall for frames 1-2; frames 3-4 each give 24 img_data_en bytes matching input, frame_done pulses, frame_err=0, frame_cnt=2.
2. Data ramp 0x00.. on cam_data -> img_data equals cam_data delayed 3 cycles; img_data=0 whenever img_data_en=0.
3. transfer_flag=0 at frame start, raised mid-frame -> that frame gives no output and img_vsync stays 1; next frame is captured.
4. One line with 7 bytes instead of 8 -> frame_done with frame_err=1; following good frame gives frame_err=0.
5. Frame with only 2 lines -> frame_err=1, frame_cnt still increments.
6. cfg_done dropped mid-capture -> img_vsync=1 and img_data_en=0 next cycle, no frame_done; after cfg_done returns, WAIT_FRAME frames are discarded again.
